// File: rtl/cdc_fifo_read_arbiter.sv
// Round-robin arbiter that shares the CDC FIFO read port among several read-domain consumers,
// granting bursts of up to MAX_BURST pops and returning registered data with a one-hot valid.
module cdc_fifo_read_arbiter #(
    parameter int unsigned NUM_REQUESTERS = 4,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned MAX_BURST      = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQUESTERS-1:0] request,
    input  logic                      fifo_empty,
    input  logic [DATA_WIDTH-1:0]     fifo_read_data,
    output logic                      fifo_increment,
    output logic [NUM_REQUESTERS-1:0] grant,
    output logic [DATA_WIDTH-1:0]     read_data,
    output logic [NUM_REQUESTERS-1:0] read_valid,
    output logic [3:0]                burst_count
);

    localparam int unsigned IdxWidth  = $clog2(NUM_REQUESTERS);
    localparam logic [3:0]  LastCount = 4'(MAX_BURST - 1);

    typedef enum logic {StIdle, StBurst} state_e;

    state_e                    state;
    logic [IdxWidth-1:0]       pointer;
    logic [IdxWidth-1:0]       sel;
    logic [IdxWidth-1:0]       idx;
    logic [NUM_REQUESTERS-1:0] sel_onehot;
    logic                      found;
    logic                      owner_request;
    logic                      pop;

    // First set request bit strictly after the last grant, wrapping round.
    always_comb begin
        sel        = pointer;
        idx        = '0;
        found      = 1'b0;
        sel_onehot = '0;
        for (int unsigned i = 1; i <= NUM_REQUESTERS; i++) begin
            idx = IdxWidth'((32'(pointer) + i) % NUM_REQUESTERS);
            if (!found && request[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        sel_onehot[sel] = 1'b1;
    end

    // grant is one-hot in StBurst, so this picks out the owner's request bit.
    assign owner_request  = |(grant & request);
    assign pop            = (state == StBurst) && owner_request && !fifo_empty;
    assign fifo_increment = pop && !reset;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= StIdle;
            grant       <= '0;
            pointer     <= IdxWidth'(NUM_REQUESTERS - 1);
            burst_count <= '0;
            read_data   <= '0;
            read_valid  <= '0;
        end else begin
            read_valid <= '0;
            case (state)
                StIdle: begin
                    if (|request && !fifo_empty) begin
                        grant       <= sel_onehot;
                        pointer     <= sel;
                        burst_count <= '0;
                        state       <= StBurst;
                    end
                end
                StBurst: begin
                    if (pop) begin
                        read_data  <= fifo_read_data;
                        read_valid <= grant;
                        if (burst_count == LastCount) begin
                            grant       <= '0;
                            burst_count <= '0;
                            state       <= StIdle;
                        end else begin
                            burst_count <= burst_count + 4'd1;
                        end
                    end else begin
                        // Owner dropped its demand or the FIFO ran dry.
                        grant       <= '0;
                        burst_count <= '0;
                        state       <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_fifo_read_arbiter.sv
// Bench for cdc_fifo_read_arbiter: cycle vectors with hand-derived expectations, a FIFO model
// feeding the DUT, and a scoreboard matching popped words against returned read data.
module tb_cdc_fifo_read_arbiter;

    logic       clock;
    logic       reset;
    logic [3:0] request;
    logic       fifo_empty;
    logic [7:0] fifo_read_data;
    logic       fifo_increment;
    logic [3:0] grant;
    logic [7:0] read_data;
    logic [3:0] read_valid;
    logic [3:0] burst_count;

    cdc_fifo_read_arbiter #(
        .NUM_REQUESTERS(4),
        .DATA_WIDTH    (8),
        .MAX_BURST     (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .request       (request),
        .fifo_empty    (fifo_empty),
        .fifo_read_data(fifo_read_data),
        .fifo_increment(fifo_increment),
        .grant         (grant),
        .read_data     (read_data),
        .read_valid    (read_valid),
        .burst_count   (burst_count)
    );

    typedef struct packed {
        logic [3:0] req;
        logic [7:0] push_n;
        logic [3:0] exp_grant;
        logic       exp_inc;
        logic [3:0] exp_valid;
        logic [3:0] exp_count;
    } vec_t;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] owner;
    } sb_t;

    vec_t       tbl[$];
    sb_t        sb[$];
    logic [7:0] fifo_q[$];
    logic [7:0] next_word;
    logic       inc_s;
    logic [3:0] owner_s;
    int         passed;
    int         total;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        else passed++;
    endtask

    task automatic fifo_update();
        fifo_empty     = (fifo_q.size() == 0);
        fifo_read_data = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
    endtask

    function automatic vec_t v(input logic [3:0] r, input int p, input logic [3:0] g,
                               input logic i, input logic [3:0] va, input logic [3:0] bc);
        vec_t x;
        x.req       = r;
        x.push_n    = 8'(p);
        x.exp_grant = g;
        x.exp_inc   = i;
        x.exp_valid = va;
        x.exp_count = bc;
        return x;
    endfunction

    // Drive inputs just after the falling edge, then sample outputs 1 time unit later.
    task automatic sample_phase(input vec_t x);
        sb_t e;
        @(negedge clock);
        request = x.req;
        for (int k = 0; k < int'(x.push_n); k++) begin
            fifo_q.push_back(next_word);
            next_word++;
        end
        fifo_update();
        #1;
        chk("grant", 32'(grant), 32'(x.exp_grant));
        chk("fifo_increment", 32'(fifo_increment), 32'(x.exp_inc));
        chk("read_valid", 32'(read_valid), 32'(x.exp_valid));
        chk("burst_count", 32'(burst_count), 32'(x.exp_count));
        if (read_valid != 4'b0) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 32'(read_valid), 32'h0);
            end else begin
                e = sb.pop_front();
                chk("read_data", 32'(read_data), 32'(e.data));
                chk("valid_owner", 32'(read_valid), 32'(e.owner));
            end
        end
        inc_s   = fifo_increment;
        owner_s = x.exp_grant;
    endtask

    // FIFO model pops just after the rising edge so the DUT captured the old head word.
    task automatic edge_phase();
        @(posedge clock);
        #1;
        if (inc_s) begin
            if (fifo_q.size() == 0) begin
                chk("pop_while_empty", 32'(inc_s), 32'h0);
            end else begin
                sb.push_back('{data: fifo_q[0], owner: owner_s});
                void'(fifo_q.pop_front());
            end
        end
        fifo_update();
    endtask

    task automatic step(input vec_t x);
        sample_phase(x);
        edge_phase();
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        next_word = 8'hA1;
        inc_s     = 1'b0;
        owner_s   = 4'b0;
        reset     = 1'b1;
        request   = 4'b0;
        fifo_update();
        repeat (2) @(posedge clock);
        #1;
        chk("reset_grant", 32'(grant), 32'h0);
        chk("reset_valid", 32'(read_valid), 32'h0);
        chk("reset_read_data", 32'(read_data), 32'h0);
        chk("reset_count", 32'(burst_count), 32'h0);
        chk("reset_increment", 32'(fifo_increment), 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // Single requester drains a 3-word FIFO (0xA1..0xA3), exits on empty.
        tbl.push_back(v(4'h1, 3, 4'h0, 0, 4'h0, 0));
        tbl.push_back(v(4'h1, 0, 4'h1, 1, 4'h0, 0));
        tbl.push_back(v(4'h1, 0, 4'h1, 1, 4'h1, 1));
        tbl.push_back(v(4'h1, 0, 4'h1, 1, 4'h1, 2));
        tbl.push_back(v(4'h1, 0, 4'h1, 0, 4'h1, 3));
        tbl.push_back(v(4'h1, 0, 4'h0, 0, 4'h0, 0));
        // All requesting, 10 words: full bursts for 1 and 2, partial for 3.
        tbl.push_back(v(4'hF, 10, 4'h0, 0, 4'h0, 0));
        for (int b = 0; b < 2; b++) begin
            logic [3:0] g;
            g = (b == 0) ? 4'h2 : 4'h4;
            tbl.push_back(v(4'hF, 0, g, 1, 4'h0, 0));
            tbl.push_back(v(4'hF, 0, g, 1, g, 1));
            tbl.push_back(v(4'hF, 0, g, 1, g, 2));
            tbl.push_back(v(4'hF, 0, g, 1, g, 3));
            tbl.push_back(v(4'hF, 0, 4'h0, 0, g, 0));
        end
        tbl.push_back(v(4'hF, 0, 4'h8, 1, 4'h0, 0));
        tbl.push_back(v(4'hF, 0, 4'h8, 1, 4'h8, 1));
        tbl.push_back(v(4'hF, 0, 4'h8, 0, 4'h8, 2));
        tbl.push_back(v(4'hF, 0, 4'h0, 0, 4'h0, 0));
        // Move pointer to 0, then request 1001 wraps to 3, then back to 0.
        tbl.push_back(v(4'h1, 1, 4'h0, 0, 4'h0, 0));
        tbl.push_back(v(4'h9, 0, 4'h1, 1, 4'h0, 0));
        tbl.push_back(v(4'h9, 0, 4'h1, 0, 4'h1, 1));
        tbl.push_back(v(4'h9, 2, 4'h0, 0, 4'h0, 0));
        tbl.push_back(v(4'h9, 0, 4'h8, 1, 4'h0, 0));
        tbl.push_back(v(4'h9, 0, 4'h8, 1, 4'h8, 1));
        tbl.push_back(v(4'h9, 0, 4'h8, 0, 4'h8, 2));
        tbl.push_back(v(4'h9, 1, 4'h0, 0, 4'h0, 0));
        tbl.push_back(v(4'h9, 0, 4'h1, 1, 4'h0, 0));
        tbl.push_back(v(4'h9, 0, 4'h1, 0, 4'h1, 1));
        tbl.push_back(v(4'h0, 0, 4'h0, 0, 4'h0, 0));
        // Owner 2 drops after 2 pops; then 3, then 0.
        tbl.push_back(v(4'hC, 6, 4'h0, 0, 4'h0, 0));
        tbl.push_back(v(4'hC, 0, 4'h4, 1, 4'h0, 0));
        tbl.push_back(v(4'hC, 0, 4'h4, 1, 4'h4, 1));
        tbl.push_back(v(4'h9, 0, 4'h4, 0, 4'h4, 2));
        tbl.push_back(v(4'h9, 0, 4'h0, 0, 4'h0, 0));
        tbl.push_back(v(4'h9, 0, 4'h8, 1, 4'h0, 0));
        tbl.push_back(v(4'h1, 0, 4'h8, 0, 4'h8, 1));
        tbl.push_back(v(4'h1, 0, 4'h0, 0, 4'h0, 0));
        tbl.push_back(v(4'h1, 0, 4'h1, 1, 4'h0, 0));
        tbl.push_back(v(4'h1, 0, 4'h1, 1, 4'h1, 1));
        tbl.push_back(v(4'h1, 0, 4'h1, 1, 4'h1, 2));
        tbl.push_back(v(4'h1, 0, 4'h1, 0, 4'h1, 3));
        tbl.push_back(v(4'h0, 0, 4'h0, 0, 4'h0, 0));
        // Empty FIFO with demand: nothing happens until a word arrives.
        for (int k = 0; k < 20; k++) tbl.push_back(v(4'h6, 0, 4'h0, 0, 4'h0, 0));
        tbl.push_back(v(4'h6, 1, 4'h0, 0, 4'h0, 0));
        tbl.push_back(v(4'h6, 0, 4'h2, 1, 4'h0, 0));
        tbl.push_back(v(4'h6, 0, 4'h2, 0, 4'h2, 1));
        tbl.push_back(v(4'h0, 0, 4'h0, 0, 4'h0, 0));

        foreach (tbl[i]) step(tbl[i]);

        // Asynchronous reset mid-burst with burst_count == 2.
        step(v(4'h2, 5, 4'h0, 0, 4'h0, 0));
        step(v(4'h2, 0, 4'h2, 1, 4'h0, 0));
        step(v(4'h2, 0, 4'h2, 1, 4'h2, 1));
        sample_phase(v(4'h2, 0, 4'h2, 1, 4'h2, 2));
        reset = 1'b1;
        #1;
        chk("async_grant", 32'(grant), 32'h0);
        chk("async_valid", 32'(read_valid), 32'h0);
        chk("async_count", 32'(burst_count), 32'h0);
        chk("async_increment", 32'(fifo_increment), 32'h0);
        fifo_q.delete();
        fifo_update();
        @(posedge clock);
        #1;
        chk("held_grant", 32'(grant), 32'h0);
        chk("held_increment", 32'(fifo_increment), 32'h0);
        chk("scoreboard_after_reset", 32'(sb.size()), 32'h0);
        sb.delete();
        @(negedge clock);
        reset = 1'b0;
        inc_s = 1'b0;
        step(v(4'h3, 2, 4'h0, 0, 4'h0, 0));
        step(v(4'h3, 0, 4'h1, 1, 4'h0, 0));
        step(v(4'h3, 0, 4'h1, 1, 4'h1, 1));
        step(v(4'h3, 0, 4'h1, 0, 4'h1, 2));
        step(v(4'h0, 0, 4'h0, 0, 4'h0, 0));

        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
